// File: rtl/modexp_host_seq_pkg.sv
// Shared constants and state encoding for the ModExp host sequencer.
// Optional watchdog: define MODEXP_SEQ_TIMEOUT_EN.
package modexp_host_seq_pkg;

    localparam int WIDTH      = 4096;
    localparam int DATA_WIDTH = 64;
    localparam int NWORDS     = WIDTH / DATA_WIDTH;
    localparam int CNT_W      = $clog2(NWORDS) + 1;

    localparam logic [4:0] EXP_COMPLETE      = 5'd9;
    localparam logic [4:0] EXP_OUTPUT_RESULT = 5'd10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CALC_R,
        S_CALC_T,
        S_CALC_N0,
        S_SEND,
        S_RUN,
        S_READ
    } seq_state_e;

endpackage

// File: rtl/modexp_host_seq_if.sv
// Host job interface: operands in, busy/done/result out.
// Carries an error flag only when MODEXP_SEQ_TIMEOUT_EN is defined.
interface modexp_host_seq_if;
    import modexp_host_seq_pkg::*;

    logic             go;
    logic [WIDTH-1:0] message;
    logic [WIDTH-1:0] exponent;
    logic [WIDTH-1:0] modulus;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
`ifdef MODEXP_SEQ_TIMEOUT_EN
    logic             error;

    modport master (
        output go, message, exponent, modulus,
        input  busy, done, result, error
    );
    modport slave (
        input  go, message, exponent, modulus,
        output busy, done, result, error
    );
`else
    modport master (
        output go, message, exponent, modulus,
        input  busy, done, result
    );
    modport slave (
        input  go, message, exponent, modulus,
        output busy, done, result
    );
`endif

endinterface

// File: rtl/modexp_host_seq_word_slicer.sv
// Selects word idx of a full-width operand for the ModExp word bus.
// Purely combinational; the caller keeps idx within 0..NWORDS-1.
module modexp_host_seq_word_slicer
    import modexp_host_seq_pkg::*;
(
    input  logic [WIDTH-1:0]      data,
    input  logic [CNT_W-1:0]      idx,
    output logic [DATA_WIDTH-1:0] word
);

    assign word = data[idx*DATA_WIDTH +: DATA_WIDTH];

endmodule

// File: rtl/modexp_host_seq.sv
// Host sequencer: precompute r, t, n' then stream a job through ModExp and read back the result.
// MODEXP_SEQ_TIMEOUT_EN adds a wait-state watchdog and an error flag on the host interface.
module modexp_host_seq
    import modexp_host_seq_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    modexp_host_seq_if.slave      host,
    output logic                  rt_go,
    output logic                  rt_mode,
    input  logic [WIDTH-1:0]      rt_value,
    input  logic                  rt_done,
    output logic                  inv_go,
    input  logic [63:0]           inv_result,
    input  logic                  inv_valid,
    output logic [DATA_WIDTH-1:0] m_buf,
    output logic [DATA_WIDTH-1:0] e_buf,
    output logic [DATA_WIDTH-1:0] n_buf,
    output logic [DATA_WIDTH-1:0] r_buf,
    output logic [DATA_WIDTH-1:0] t_buf,
    output logic [63:0]           nprime0,
    output logic                  start_input,
    output logic                  start_compute,
    output logic                  get_result,
    input  logic [4:0]            exp_state,
    input  logic [DATA_WIDTH-1:0] res_out
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(NWORDS - 1);

    seq_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [WIDTH-1:0] m_q, m_d, e_q, e_d, n_q, n_d;
    logic [WIDTH-1:0] r_q, r_d, t_q, t_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [63:0]      np_q, np_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             rt_go_q, rt_go_d, rt_mode_q, rt_mode_d;
    logic             inv_go_q, inv_go_d;
    logic             start_input_q, start_input_d;
    logic             start_compute_q, start_compute_d;
    logic             get_result_q, get_result_d;

`ifdef MODEXP_SEQ_TIMEOUT_EN
    localparam logic [31:0] WDOG_LAST = 32'h00FF_FFFF;
    logic [31:0] wdog_q, wdog_d;
    logic        err_q, err_d;
    logic        in_wait;
`endif

    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        m_d             = m_q;
        e_d             = e_q;
        n_d             = n_q;
        r_d             = r_q;
        t_d             = t_q;
        np_d            = np_q;
        result_d        = result_q;
        busy_d          = busy_q;
        done_d          = 1'b0;
        rt_go_d         = 1'b0;
        rt_mode_d       = rt_mode_q;
        inv_go_d        = 1'b0;
        start_input_d   = start_input_q;
        start_compute_d = 1'b0;
        get_result_d    = get_result_q;
`ifdef MODEXP_SEQ_TIMEOUT_EN
        err_d           = err_q;
        in_wait         = 1'b0;
`endif
        // Saturating word counter: it parks on the last word instead of wrapping.
        cnt_inc = (cnt_q == LAST) ? cnt_q : cnt_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (host.go) begin
                    m_d       = host.message;
                    e_d       = host.exponent;
                    n_d       = host.modulus;
                    result_d  = '0;
                    busy_d    = 1'b1;
                    rt_go_d   = 1'b1;
                    rt_mode_d = 1'b0;
`ifdef MODEXP_SEQ_TIMEOUT_EN
                    err_d     = 1'b0;
`endif
                    state_d   = S_CALC_R;
                end
            end
            S_CALC_R: begin
                if (rt_done && !rt_go_q) begin
                    r_d       = rt_value;
                    rt_go_d   = 1'b1;
                    rt_mode_d = 1'b1;
                    state_d   = S_CALC_T;
                end
            end
            S_CALC_T: begin
                if (rt_done && !rt_go_q) begin
                    t_d      = rt_value;
                    inv_go_d = 1'b1;
                    state_d  = S_CALC_N0;
                end
            end
            S_CALC_N0: begin
                if (inv_valid && !inv_go_q) begin
                    np_d          = inv_result;
                    cnt_d         = '0;
                    start_input_d = 1'b1;
                    state_d       = S_SEND;
                end
            end
            S_SEND: begin
                if (cnt_q == LAST) begin
                    start_input_d   = 1'b0;
                    start_compute_d = 1'b1;
                    get_result_d    = 1'b1;
                    state_d         = S_RUN;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            S_RUN: begin
                if (exp_state == EXP_COMPLETE) begin
                    start_compute_d = 1'b1;
                    cnt_d           = '0;
                    state_d         = S_READ;
                end
            end
            S_READ: begin
                result_d[cnt_q*DATA_WIDTH +: DATA_WIDTH] = res_out;
                if (cnt_q == LAST) begin
                    get_result_d = 1'b0;
                    done_d       = 1'b1;
                    busy_d       = 1'b0;
                    state_d      = S_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: state_d = S_IDLE;
        endcase

`ifdef MODEXP_SEQ_TIMEOUT_EN
        in_wait = (state_q == S_CALC_R) || (state_q == S_CALC_T) ||
                  (state_q == S_CALC_N0) || (state_q == S_RUN);
        if (in_wait && wdog_q == WDOG_LAST) begin
            state_d         = S_IDLE;
            busy_d          = 1'b0;
            done_d          = 1'b1;
            err_d           = 1'b1;
            result_d        = '0;
            rt_go_d         = 1'b0;
            inv_go_d        = 1'b0;
            start_input_d   = 1'b0;
            start_compute_d = 1'b0;
            get_result_d    = 1'b0;
        end
        // Reload on every state entry so each wait is timed on its own.
        wdog_d = (state_d != state_q) ? '0 : wdog_q + 1'b1;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q         <= S_IDLE;
            cnt_q           <= '0;
            m_q             <= '0;
            e_q             <= '0;
            n_q             <= '0;
            r_q             <= '0;
            t_q             <= '0;
            np_q            <= '0;
            result_q        <= '0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            rt_go_q         <= 1'b0;
            rt_mode_q       <= 1'b0;
            inv_go_q        <= 1'b0;
            start_input_q   <= 1'b0;
            start_compute_q <= 1'b0;
            get_result_q    <= 1'b0;
`ifdef MODEXP_SEQ_TIMEOUT_EN
            wdog_q          <= '0;
            err_q           <= 1'b0;
`endif
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            m_q             <= m_d;
            e_q             <= e_d;
            n_q             <= n_d;
            r_q             <= r_d;
            t_q             <= t_d;
            np_q            <= np_d;
            result_q        <= result_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            rt_go_q         <= rt_go_d;
            rt_mode_q       <= rt_mode_d;
            inv_go_q        <= inv_go_d;
            start_input_q   <= start_input_d;
            start_compute_q <= start_compute_d;
            get_result_q    <= get_result_d;
`ifdef MODEXP_SEQ_TIMEOUT_EN
            wdog_q          <= wdog_d;
            err_q           <= err_d;
`endif
        end
    end

    modexp_host_seq_word_slicer u_m (.data(m_q), .idx(cnt_q), .word(m_buf));
    modexp_host_seq_word_slicer u_e (.data(e_q), .idx(cnt_q), .word(e_buf));
    modexp_host_seq_word_slicer u_n (.data(n_q), .idx(cnt_q), .word(n_buf));
    modexp_host_seq_word_slicer u_r (.data(r_q), .idx(cnt_q), .word(r_buf));
    modexp_host_seq_word_slicer u_t (.data(t_q), .idx(cnt_q), .word(t_buf));

    assign host.busy     = busy_q;
    assign host.done     = done_q;
    assign host.result   = result_q;
`ifdef MODEXP_SEQ_TIMEOUT_EN
    assign host.error    = err_q;
`endif
    assign rt_go         = rt_go_q;
    assign rt_mode       = rt_mode_q;
    assign inv_go        = inv_go_q;
    assign nprime0       = np_q;
    assign start_input   = start_input_q;
    assign start_compute = start_compute_q;
    assign get_result    = get_result_q;

endmodule

// File: tb/tb_modexp_host_seq.sv
// Randomized bench for modexp_host_seq with behavioural rtMod, modInv and ModExp stand-ins.
// Expected results come from plain modular exponentiation of the job operands.
module tb_modexp_host_seq;
    import modexp_host_seq_pkg::*;

    logic                  clk = 1'b0;
    logic                  reset;
    logic                  rt_go, rt_mode, rt_done, inv_go, inv_valid;
    logic [WIDTH-1:0]      rt_value;
    logic [63:0]           inv_result, nprime0;
    logic [DATA_WIDTH-1:0] m_buf, e_buf, n_buf, r_buf, t_buf, res_out;
    logic                  start_input, start_compute, get_result;
    logic [4:0]            exp_state;

    modexp_host_seq_if hif ();

    modexp_host_seq dut (
        .clk(clk), .reset(reset), .host(hif.slave),
        .rt_go(rt_go), .rt_mode(rt_mode), .rt_value(rt_value), .rt_done(rt_done),
        .inv_go(inv_go), .inv_result(inv_result), .inv_valid(inv_valid),
        .m_buf(m_buf), .e_buf(e_buf), .n_buf(n_buf), .r_buf(r_buf), .t_buf(t_buf),
        .nprime0(nprime0), .start_input(start_input), .start_compute(start_compute),
        .get_result(get_result), .exp_state(exp_state), .res_out(res_out)
    );

    always #5 clk = ~clk;

    int vec_cnt = 0;
    int err_cnt = 0;

    function automatic logic [63:0] modpow(input logic [63:0] b, input logic [63:0] e,
                                           input logic [63:0] n);
        logic [127:0] acc, base, nn;
        nn   = 128'(n);
        acc  = 128'(64'd1 % n);
        base = 128'(b % n);
        for (int i = 0; i < 64; i++) begin
            if (e[i]) acc = (acc * base) % nn;
            base = (base * base) % nn;
        end
        return acc[63:0];
    endfunction

    function automatic logic [63:0] fold(input logic [WIDTH-1:0] v);
        logic [63:0] f = '0;
        for (int i = 0; i < NWORDS; i++) f = f ^ v[i*64 +: 64];
        return f;
    endfunction

    function automatic logic [WIDTH-1:0] rand_wide();
        logic [WIDTH-1:0] v;
        for (int i = 0; i < WIDTH/32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic chk(input string tag, input logic [WIDTH-1:0] got,
                       input logic [WIDTH-1:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got low=%h fold=%h, expected low=%h fold=%h",
                     tag, got[63:0], fold(got), exp[63:0], fold(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // rtMod stand-in: answers each rt_go after a few cycles with the value for its mode.
    logic [WIDTH-1:0] r_val, t_val;
    logic [63:0]      np_val;
    logic             inv_block = 1'b0;
    int               rt_wait = 0, inv_wait = 0;
    logic             rt_pend_mode = 1'b0;
    int               rtgo_total = 0, invgo_total = 0, done_total = 0, si_total = 0;
    logic             mode_log [0:255];

    always @(posedge clk) begin
        rt_done <= 1'b0;
        if (reset) begin
            rt_wait <= 0;
        end else if (rt_go) begin
            rt_wait      <= 2 + int'($urandom_range(0, 4));
            rt_pend_mode <= rt_mode;
            mode_log[rtgo_total % 256] <= rt_mode;
            rtgo_total   <= rtgo_total + 1;
        end else if (rt_wait > 0) begin
            rt_wait <= rt_wait - 1;
            if (rt_wait == 1) begin
                rt_done  <= 1'b1;
                rt_value <= rt_pend_mode ? t_val : r_val;
            end
        end
    end

    always @(posedge clk) begin
        inv_valid <= 1'b0;
        if (reset) begin
            inv_wait <= 0;
        end else if (inv_go) begin
            inv_wait    <= 2 + int'($urandom_range(0, 4));
            invgo_total <= invgo_total + 1;
        end else if (inv_wait > 0) begin
            inv_wait <= inv_wait - 1;
            if (inv_wait == 1 && !inv_block) begin
                inv_valid  <= 1'b1;
                inv_result <= np_val;
            end
        end
        if (!reset && hif.done) done_total <= done_total + 1;
    end

    // ModExp stand-in: collects words, computes, then streams the result out word by word.
    logic [WIDTH-1:0] m_rx, e_rx, n_rx, r_rx, t_rx;
    logic [63:0]      np_rx, x_res;
    logic [4:0]       x_state = 5'd0;
    int               ld_cnt = 0, x_lat = 0, ridx = 0;
    logic             spur = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            x_state <= 5'd0;
            ld_cnt  <= 0;
            ridx    <= 0;
        end else if (start_input) begin
            if (ld_cnt < NWORDS) begin
                m_rx[ld_cnt*64 +: 64] <= m_buf;
                e_rx[ld_cnt*64 +: 64] <= e_buf;
                n_rx[ld_cnt*64 +: 64] <= n_buf;
                r_rx[ld_cnt*64 +: 64] <= r_buf;
                t_rx[ld_cnt*64 +: 64] <= t_buf;
            end
            ld_cnt   <= ld_cnt + 1;
            si_total <= si_total + 1;
            x_state  <= 5'd0;
        end else if (start_compute && x_state == 5'd9) begin
            x_state <= 5'd10;
            ridx    <= 1;
        end else if (start_compute) begin
            x_state <= 5'd1;
            x_lat   <= 3 + int'($urandom_range(0, 7));
            np_rx   <= nprime0;
            ld_cnt  <= 0;
            ridx    <= 0;
        end else if (x_state == 5'd1) begin
            if (x_lat == 0) begin
                x_state <= 5'd9;
                x_res   <= modpow(m_rx[63:0], e_rx[63:0], n_rx[63:0]);
            end else begin
                x_lat <= x_lat - 1;
            end
        end else if (x_state == 5'd10 && ridx < NWORDS) begin
            ridx <= ridx + 1;
        end
    end

    assign exp_state = spur ? 5'd9 : x_state;
    assign res_out   = (x_state == 5'd9 || (x_state == 5'd10 && ridx < NWORDS)) ?
                       ((ridx == 0) ? x_res : 64'h0) : 64'hBAD0_BAD0_BAD0_BAD0;

    int snap_done, snap_si, snap_rt, snap_inv;

    task automatic launch(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] e,
                          input logic [WIDTH-1:0] n, input int hold);
        r_val  = rand_wide();
        t_val  = rand_wide();
        np_val = {$urandom, $urandom};
        snap_done = done_total;
        snap_si   = si_total;
        snap_rt   = rtgo_total;
        snap_inv  = invgo_total;
        hif.message  = m;
        hif.exponent = e;
        hif.modulus  = n;
        hif.go       = 1'b1;
        tick();
        chk("busy_after_go", WIDTH'(hif.busy), WIDTH'(1'b1));
        repeat (hold - 1) tick();
        hif.go = 1'b0;
    endtask

    task automatic finish(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] e,
                          input logic [WIDTH-1:0] n);
        logic [WIDTH-1:0] exp_res;
        int k = 0;
        exp_res = WIDTH'(modpow(m[63:0], e[63:0], n[63:0]));
        while (!hif.done && k < 20000) begin
            tick();
            k++;
        end
        chk("done_seen", WIDTH'(k < 20000), WIDTH'(1'b1));
        chk("result", hif.result, exp_res);
        chk("busy_at_done", WIDTH'(hif.busy), WIDTH'(1'b0));
`ifdef MODEXP_SEQ_TIMEOUT_EN
        chk("error_clean", WIDTH'(hif.error), WIDTH'(1'b0));
`endif
        tick();
        chk("done_one_cycle", WIDTH'(hif.done), WIDTH'(1'b0));
        repeat (10) tick();
        chk("done_count", WIDTH'(done_total - snap_done), WIDTH'(1));
        chk("start_input_cycles", WIDTH'(si_total - snap_si), WIDTH'(NWORDS));
        chk("rt_go_count", WIDTH'(rtgo_total - snap_rt), WIDTH'(2));
        chk("rt_mode_first", WIDTH'(mode_log[snap_rt % 256]), WIDTH'(1'b0));
        chk("rt_mode_second", WIDTH'(mode_log[(snap_rt + 1) % 256]), WIDTH'(1'b1));
        chk("inv_go_count", WIDTH'(invgo_total - snap_inv), WIDTH'(1));
        chk("stream_m", m_rx, m);
        chk("stream_e", e_rx, e);
        chk("stream_n", n_rx, n);
        chk("stream_r", r_rx, r_val);
        chk("stream_t", t_rx, t_val);
        chk("nprime0", WIDTH'(np_rx), WIDTH'(np_val));
        chk("result_held", hif.result, exp_res);
        chk("idle_after_job", WIDTH'(hif.busy), WIDTH'(1'b0));
    endtask

    task automatic do_job(input logic [WIDTH-1:0] m, input logic [WIDTH-1:0] e,
                          input logic [WIDTH-1:0] n, input int hold);
        launch(m, e, n, hold);
        finish(m, e, n);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_strobes"},
            WIDTH'({rt_go, rt_mode, inv_go, start_input, start_compute,
                    get_result, hif.busy, hif.done}), WIDTH'(8'h00));
        chk({tag, "_result"}, hif.result, WIDTH'(0));
        chk({tag, "_nprime0"}, WIDTH'(nprime0), WIDTH'(0));
        chk({tag, "_bufs"}, WIDTH'(m_buf | e_buf | n_buf | r_buf | t_buf), WIDTH'(0));
    endtask

    initial begin
        logic [63:0] rn, rm, re;
        int k;
        reset        = 1'b1;
        hif.go       = 1'b0;
        hif.message  = '0;
        hif.exponent = '0;
        hif.modulus  = '0;
        r_val        = '0;
        t_val        = '0;
        np_val       = '0;
        repeat (3) tick();
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        do_job(WIDTH'(8), WIDTH'(13), WIDTH'(77), 1);
        do_job(WIDTH'(50), WIDTH'(37), WIDTH'(77), 1);
        do_job(WIDTH'(8), WIDTH'(13), WIDTH'(77), 10);
        do_job(WIDTH'(3), WIDTH'(200), WIDTH'(1009), 1);

        // Spurious COMPLETE while the T precompute is still outstanding.
        launch(WIDTH'(8), WIDTH'(13), WIDTH'(77), 1);
        k = 0;
        while (!(rt_go && rt_mode) && k < 100) begin
            tick();
            k++;
        end
        chk("reach_calc_t", WIDTH'(k < 100), WIDTH'(1'b1));
        spur = 1'b1;
        tick();
        tick();
        spur = 1'b0;
        finish(WIDTH'(8), WIDTH'(13), WIDTH'(77));

        // Reset while word 20 is on the bus.
        launch(WIDTH'(12345), WIDTH'(777), WIDTH'(99991), 1);
        k = 0;
        while (!(start_input && ld_cnt == 20) && k < 500) begin
            tick();
            k++;
        end
        chk("reach_word20", WIDTH'(k < 500), WIDTH'(1'b1));
        reset = 1'b1;
        tick();
        check_all_zero("midreset");
        reset = 1'b0;
        tick();
        do_job(WIDTH'(8), WIDTH'(13), WIDTH'(77), 1);

        for (int j = 0; j < 6; j++) begin
            rn = ({$urandom, $urandom} >> 2) | 64'h1 | (64'h1 << 40);
            rm = {$urandom, $urandom} % rn;
            re = {$urandom, $urandom};
            do_job(WIDTH'(rm), WIDTH'(re), WIDTH'(rn), 1 + int'($urandom_range(0, 3)));
        end

`ifdef MODEXP_SEQ_TIMEOUT_EN
        inv_block = 1'b1;
        launch(WIDTH'(8), WIDTH'(13), WIDTH'(77), 1);
        k = 0;
        while (!hif.done && k < (1 << 24) + 1000) begin
            tick();
            k++;
        end
        chk("timeout_done", WIDTH'(k < (1 << 24) + 1000), WIDTH'(1'b1));
        chk("timeout_late", WIDTH'(k > (1 << 24) - 100), WIDTH'(1'b1));
        chk("timeout_error", WIDTH'(hif.error), WIDTH'(1'b1));
        chk("timeout_result", hif.result, WIDTH'(0));
        inv_block = 1'b0;
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
